// File: rtl/ocdp_dp.sv
// OCDP data plane: 16 KiB dual-ported message buffer with a WCI control/config slave,
// a WMI burst slave on port A and a 32-bit tagged server request/response path on port B.
module ocdp_dp #(
    parameter int WMI_S0_DATAPATH_WIDTH = 32,
    parameter int HAS_PUSH_LOGIC        = 1,
    parameter int HAS_PULL_LOGIC        = 1,
    parameter int HAS_DEBUG_LOGIC       = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic [15:0]                          pciDevice,
    input  logic [2:0]                           wci_s_MCmd,
    input  logic                                 wci_s_MAddrSpace,
    input  logic [3:0]                           wci_s_MByteEn,
    input  logic [31:0]                          wci_s_MAddr,
    input  logic [31:0]                          wci_s_MData,
    output logic [1:0]                           wci_s_SResp,
    output logic [31:0]                          wci_s_SData,
    output logic                                 wci_s_SThreadBusy,
    output logic [1:0]                           wci_s_SFlag,
    input  logic [1:0]                           wci_s_MFlag,
    input  logic [66:0]                          wti_s_req,
    input  logic [2:0]                           wmiS0_MCmd,
    input  logic                                 wmiS0_MReqLast,
    input  logic                                 wmiS0_MReqInfo,
    input  logic                                 wmiS0_MAddrSpace,
    input  logic [13:0]                          wmiS0_MAddr,
    input  logic [11:0]                          wmiS0_MBurstLength,
    input  logic                                 wmiS0_MDataValid,
    input  logic                                 wmiS0_MDataLast,
    input  logic [WMI_S0_DATAPATH_WIDTH-1:0]     wmiS0_MData,
    input  logic [WMI_S0_DATAPATH_WIDTH/4-1:0]   wmiS0_MDataByteEn,
    output logic [1:0]                           wmiS0_SResp,
    output logic [WMI_S0_DATAPATH_WIDTH-1:0]     wmiS0_SData,
    output logic                                 wmiS0_SThreadBusy,
    output logic                                 wmiS0_SDataThreadBusy,
    output logic                                 wmiS0_SRespLast,
    output logic [31:0]                          wmiS0_SFlag,
    input  logic [31:0]                          wmiS0_arg_mFlag,
    input  logic                                 wmiS0_MReset_n,
    output logic                                 wmiS0_SReset_n,
    input  logic [152:0]                         server_request_put,
    input  logic                                 EN_server_request_put,
    output logic                                 RDY_server_request_put,
    output logic [152:0]                         server_response_get,
    input  logic                                 EN_server_response_get,
    output logic                                 RDY_server_response_get
);
    localparam int DW    = WMI_S0_DATAPATH_WIDTH;
    localparam int NB    = DW / 8;
    localparam int BSH   = $clog2(NB);
    localparam int AW    = 14 - BSH;
    localparam int WORDS = 1 << AW;

    if (!(DW == 32 || DW == 64 || DW == 128 || DW == 256)) begin : g_bad_dw
        $error("ocdp_dp: WMI_S0_DATAPATH_WIDTH must be 32, 64, 128 or 256");
    end

    logic [DW-1:0]  mem [WORDS];
    logic           enable;
    logic [31:0]    msg_count, last_mflag, sflag_reg, cfg_rdata, wci_wmask;
    logic [63:0]    time_reg;
    logic           wci_resp_q, wmi_resp_q;
    logic           wci_wr, wci_rd;
    logic [2:0]     ctl_op;
    logic           wmi_busy, wmi_req_wr, wmi_req_rd, wmi_beat;
    logic [AW-1:0]  req_word, beat_addr, wr_addr, rd_addr, rd_sel;
    logic [11:0]    rd_len, rd_rem;
    logic           rd_active;
    logic           srv_put, srv_wr;
    logic [13:0]    srv_addr;
    logic [AW-1:0]  srv_word;
    logic [2:0]     srv_lane;
    logic [DW-1:0]  srv_rd_word;
    logic           s1_valid;
    logic [7:0]     s1_tag;
    logic [13:0]    s1_addr;
    logic [2:0]     s1_lane;
    logic [31:0]    s1_data;
    logic [152:0]   resp_new, fifo0, fifo1;
    logic [1:0]     fifo_cnt;
    logic           fifo_enq, fifo_deq;
    logic           unused;

    assign unused = ^{wci_s_MFlag, wmiS0_MReqLast, wmiS0_MReqInfo, wmiS0_MAddrSpace, wmiS0_MReset_n,
                      wmiS0_MDataByteEn[DW/4-1:NB], wci_s_MAddr[31:8], server_request_put[143:142],
                      server_request_put[127:32]};

    assign wci_wr    = (wci_s_MCmd == 3'd1);
    assign wci_rd    = (wci_s_MCmd == 3'd2);
    assign ctl_op    = wci_s_MAddr[4:2];
    assign wci_wmask = {{8{wci_s_MByteEn[3]}}, {8{wci_s_MByteEn[2]}}, {8{wci_s_MByteEn[1]}}, {8{wci_s_MByteEn[0]}}};

    always_comb begin
        cfg_rdata = 32'h0;
        case (wci_s_MAddr[7:0])
            8'h00: cfg_rdata = {1'(HAS_DEBUG_LOGIC != 0), 1'(HAS_PULL_LOGIC != 0), 1'(HAS_PUSH_LOGIC != 0), 21'b0, 8'(NB)};
            8'h04: cfg_rdata = {31'b0, enable};
            8'h08: cfg_rdata = (HAS_DEBUG_LOGIC != 0) ? msg_count : 32'h0;
            8'h0C: cfg_rdata = {16'b0, pciDevice};
            8'h10: cfg_rdata = time_reg[31:0];
            8'h14: cfg_rdata = time_reg[63:32];
            8'h18: cfg_rdata = last_mflag;
            8'h1C: cfg_rdata = sflag_reg;
            default: cfg_rdata = 32'h0;
        endcase
    end

    assign wmi_busy   = ~enable | rd_active;
    assign wmi_req_wr = (wmiS0_MCmd == 3'd1) && !wmi_busy;
    assign wmi_req_rd = (wmiS0_MCmd == 3'd2) && !wmi_busy;
    assign wmi_beat   = wmiS0_MDataValid && enable;
    assign req_word   = AW'(wmiS0_MAddr >> BSH);
    // A data beat arriving with its write request uses the request address directly.
    assign beat_addr  = wmi_req_wr ? req_word : wr_addr;
    assign rd_sel     = wmi_req_rd ? req_word : rd_addr;
    assign rd_len     = (wmiS0_MBurstLength == 12'd0) ? 12'd1 : wmiS0_MBurstLength;

    assign srv_put  = EN_server_request_put && RDY_server_request_put;
    assign srv_wr   = server_request_put[152];
    assign srv_addr = server_request_put[141:128];
    assign srv_word = AW'(srv_addr >> BSH);
    assign srv_lane = 3'((srv_addr & 14'(NB - 1)) >> 2);

    always_comb begin
        s1_data = 32'hFFFF_FFFF;
        if (HAS_PULL_LOGIC != 0) s1_data = srv_rd_word[32*int'(s1_lane) +: 32];
    end
    assign resp_new = {1'b1, s1_tag, 2'b0, s1_addr, 96'b0, s1_data};

    // NOTE: the buffer has no reset; its contents are undefined after reset and
    // resetting a RAM array would prevent it mapping onto block memory.
    always_ff @(posedge CLK) begin
        if (srv_put && srv_wr && HAS_PUSH_LOGIC != 0)
            mem[srv_word][32*int'(srv_lane) +: 32] <= server_request_put[31:0];
        // The WMI write comes later in this block, so it wins on overlapping bytes.
        if (wmi_beat)
            for (int b = 0; b < NB; b++)
                if (wmiS0_MDataByteEn[b]) mem[beat_addr][8*b +: 8] <= wmiS0_MData[8*b +: 8];
        srv_rd_word <= mem[srv_word];
        wmiS0_SData <= mem[rd_sel];
    end

    assign fifo_enq = s1_valid;
    assign fifo_deq = EN_server_response_get && (fifo_cnt != 2'd0);

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; later assignments in this block deliberately take priority.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            enable     <= 1'b0;
            msg_count  <= 32'h0;
            time_reg   <= 64'h0;
            last_mflag <= 32'h0;
            sflag_reg  <= 32'h0;
            wci_resp_q <= 1'b0;
            wci_s_SData <= 32'h0;
            wmi_resp_q <= 1'b0;
            wmiS0_SRespLast <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_rem     <= 12'd0;
            rd_active  <= 1'b0;
            s1_valid   <= 1'b0;
            fifo_cnt   <= 2'd0;
        end else begin
            wci_resp_q <= wci_wr || wci_rd;
            if (wci_rd) wci_s_SData <= wci_s_MAddrSpace ? cfg_rdata : 32'hC0DE_4201;
            if (wti_s_req[66:64] == 3'd1) time_reg <= wti_s_req[63:0];
            if (wmi_beat && wmiS0_MDataLast) msg_count <= msg_count + 32'd1;
            if (wci_rd && !wci_s_MAddrSpace) begin
                if (ctl_op == 3'd0) msg_count <= 32'h0;
                if (ctl_op == 3'd1) enable <= 1'b1;
                if (ctl_op == 3'd2) enable <= 1'b0;
            end
            if (wci_wr && wci_s_MAddrSpace) begin
                if (wci_s_MAddr[7:0] == 8'h04 && wci_s_MByteEn[0]) enable <= wci_s_MData[0];
                if (wci_s_MAddr[7:0] == 8'h1C) sflag_reg <= (sflag_reg & ~wci_wmask) | (wci_s_MData & wci_wmask);
            end

            if (wmi_req_wr) last_mflag <= wmiS0_arg_mFlag;
            if (wmi_beat) wr_addr <= beat_addr + AW'(1);
            else if (wmi_req_wr) wr_addr <= req_word;

            if (wmi_req_rd) begin
                wmi_resp_q      <= 1'b1;
                wmiS0_SRespLast <= (rd_len == 12'd1);
                rd_addr         <= req_word + AW'(1);
                rd_rem          <= rd_len - 12'd1;
                rd_active       <= (rd_len > 12'd1);
            end else if (rd_active) begin
                wmi_resp_q      <= 1'b1;
                wmiS0_SRespLast <= (rd_rem == 12'd1);
                rd_addr         <= rd_addr + AW'(1);
                rd_rem          <= rd_rem - 12'd1;
                rd_active       <= (rd_rem > 12'd1);
            end else begin
                wmi_resp_q      <= 1'b0;
                wmiS0_SRespLast <= 1'b0;
            end

            s1_valid <= srv_put && !srv_wr;
            case ({fifo_enq, fifo_deq})
                2'b10: begin
                    if (fifo_cnt == 2'd0) fifo0 <= resp_new;
                    else fifo1 <= resp_new;
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo0    <= fifo1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) fifo0 <= resp_new;
                    else begin
                        fifo0 <= fifo1;
                        fifo1 <= resp_new;
                    end
                end
                default: ;
            endcase
        end
        if (!srv_put || srv_wr) begin
            s1_tag  <= s1_tag;
            s1_addr <= s1_addr;
            s1_lane <= s1_lane;
        end else begin
            s1_tag  <= server_request_put[151:144];
            s1_addr <= srv_addr;
            s1_lane <= srv_lane;
        end
    end

    assign wci_s_SResp             = {1'b0, wci_resp_q};
    assign wci_s_SThreadBusy       = RST_N;
    assign wci_s_SFlag             = {1'b0, enable};
    assign wmiS0_SResp             = {1'b0, wmi_resp_q};
    assign wmiS0_SThreadBusy       = wmi_busy;
    assign wmiS0_SDataThreadBusy   = ~enable;
    assign wmiS0_SFlag             = sflag_reg;
    assign wmiS0_SReset_n          = ~RST_N;
    // Room must remain for every read already in the pipeline plus the one being offered.
    assign RDY_server_request_put  = ~RST_N && ((3'(fifo_cnt) + 3'(s1_valid)) < 3'd2);
    assign RDY_server_response_get = ~RST_N && (fifo_cnt != 2'd0);
    assign server_response_get     = fifo0;
endmodule

// File: tb/tb_ocdp_dp.sv
// Directed self-checking bench for ocdp_dp at a 64-bit WMI width.
module tb_ocdp_dp;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST_N;
    logic [15:0] pciDevice;
    logic [2:0] wci_s_MCmd;
    logic wci_s_MAddrSpace;
    logic [3:0] wci_s_MByteEn;
    logic [31:0] wci_s_MAddr, wci_s_MData;
    logic [1:0] wci_s_SResp;
    logic [31:0] wci_s_SData;
    logic wci_s_SThreadBusy;
    logic [1:0] wci_s_SFlag, wci_s_MFlag;
    logic [66:0] wti_s_req;
    logic [2:0] wmiS0_MCmd;
    logic wmiS0_MReqLast, wmiS0_MReqInfo, wmiS0_MAddrSpace;
    logic [13:0] wmiS0_MAddr;
    logic [11:0] wmiS0_MBurstLength;
    logic wmiS0_MDataValid, wmiS0_MDataLast;
    logic [63:0] wmiS0_MData;
    logic [15:0] wmiS0_MDataByteEn;
    logic [1:0] wmiS0_SResp;
    logic [63:0] wmiS0_SData;
    logic wmiS0_SThreadBusy, wmiS0_SDataThreadBusy, wmiS0_SRespLast;
    logic [31:0] wmiS0_SFlag, wmiS0_arg_mFlag;
    logic wmiS0_MReset_n, wmiS0_SReset_n;
    logic [152:0] server_request_put, server_response_get;
    logic EN_server_request_put, RDY_server_request_put;
    logic EN_server_response_get, RDY_server_response_get;

    ocdp_dp #(.WMI_S0_DATAPATH_WIDTH(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .pciDevice(pciDevice),
        .wci_s_MCmd(wci_s_MCmd), .wci_s_MAddrSpace(wci_s_MAddrSpace), .wci_s_MByteEn(wci_s_MByteEn),
        .wci_s_MAddr(wci_s_MAddr), .wci_s_MData(wci_s_MData), .wci_s_SResp(wci_s_SResp),
        .wci_s_SData(wci_s_SData), .wci_s_SThreadBusy(wci_s_SThreadBusy), .wci_s_SFlag(wci_s_SFlag),
        .wci_s_MFlag(wci_s_MFlag), .wti_s_req(wti_s_req),
        .wmiS0_MCmd(wmiS0_MCmd), .wmiS0_MReqLast(wmiS0_MReqLast), .wmiS0_MReqInfo(wmiS0_MReqInfo),
        .wmiS0_MAddrSpace(wmiS0_MAddrSpace), .wmiS0_MAddr(wmiS0_MAddr), .wmiS0_MBurstLength(wmiS0_MBurstLength),
        .wmiS0_MDataValid(wmiS0_MDataValid), .wmiS0_MDataLast(wmiS0_MDataLast), .wmiS0_MData(wmiS0_MData),
        .wmiS0_MDataByteEn(wmiS0_MDataByteEn), .wmiS0_SResp(wmiS0_SResp), .wmiS0_SData(wmiS0_SData),
        .wmiS0_SThreadBusy(wmiS0_SThreadBusy), .wmiS0_SDataThreadBusy(wmiS0_SDataThreadBusy),
        .wmiS0_SRespLast(wmiS0_SRespLast), .wmiS0_SFlag(wmiS0_SFlag), .wmiS0_arg_mFlag(wmiS0_arg_mFlag),
        .wmiS0_MReset_n(wmiS0_MReset_n), .wmiS0_SReset_n(wmiS0_SReset_n),
        .server_request_put(server_request_put), .EN_server_request_put(EN_server_request_put),
        .RDY_server_request_put(RDY_server_request_put), .server_response_get(server_response_get),
        .EN_server_response_get(EN_server_response_get), .RDY_server_response_get(RDY_server_response_get)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [152:0] srv_msg(input logic wr, input logic [7:0] tag,
                                             input logic [13:0] a, input logic [31:0] d);
        return {wr, tag, 2'b0, a, 96'b0, d};
    endfunction

    task automatic wci_cmd(input logic [2:0] cmd, input logic sp, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        wci_s_MCmd = cmd; wci_s_MAddrSpace = sp; wci_s_MAddr = {24'h0, a};
        wci_s_MData = d; wci_s_MByteEn = be;
        step();
        wci_s_MCmd = 3'd0;
    endtask

    logic [63:0] wd [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wd[0] = 64'h0123_4567_89AB_CDEF; wd[1] = 64'hFEDC_BA98_7654_3210;
        wd[2] = 64'h1111_2222_3333_4444; wd[3] = 64'hA5A5_5A5A_C3C3_3C3C;
        RST_N = 1'b1; pciDevice = 16'hBEEF;
        wci_s_MCmd = 3'd0; wci_s_MAddrSpace = 1'b0; wci_s_MByteEn = 4'h0; wci_s_MAddr = 32'h0;
        wci_s_MData = 32'h0; wci_s_MFlag = 2'b0; wti_s_req = 67'h0;
        wmiS0_MCmd = 3'd0; wmiS0_MReqLast = 1'b0; wmiS0_MReqInfo = 1'b0; wmiS0_MAddrSpace = 1'b0;
        wmiS0_MAddr = 14'h0; wmiS0_MBurstLength = 12'd0; wmiS0_MDataValid = 1'b0; wmiS0_MDataLast = 1'b0;
        wmiS0_MData = 64'h0; wmiS0_MDataByteEn = 16'h0; wmiS0_arg_mFlag = 32'h0; wmiS0_MReset_n = 1'b1;
        server_request_put = 153'h0; EN_server_request_put = 1'b0; EN_server_response_get = 1'b0;
        repeat (3) step();

        check("rst_wci_sresp", 160'(wci_s_SResp), 160'(2'd0));
        check("rst_wci_busy", 160'(wci_s_SThreadBusy), 160'(1'b1));
        check("rst_sreset_n", 160'(wmiS0_SReset_n), 160'(1'b0));
        check("rst_rdy_put", 160'(RDY_server_request_put), 160'(1'b0));
        check("rst_rdy_get", 160'(RDY_server_response_get), 160'(1'b0));
        check("rst_sflag", 160'(wmiS0_SFlag), 160'(32'h0));

        RST_N = 1'b0;
        step();
        check("idle_wmi_busy", 160'(wmiS0_SThreadBusy), 160'(1'b1));
        check("idle_rdy_put", 160'(RDY_server_request_put), 160'(1'b1));

        wci_cmd(3'd2, 1'b1, 8'h00, 32'h0, 4'hF);
        check("cfg00_sresp", 160'(wci_s_SResp), 160'(2'd1));
        check("cfg00_data", 160'(wci_s_SData), 160'(32'hE000_0008));
        step();
        check("cfg00_sresp_drop", 160'(wci_s_SResp), 160'(2'd0));

        wci_cmd(3'd2, 1'b0, 8'h04, 32'h0, 4'hF);
        check("ctl_op1_data", 160'(wci_s_SData), 160'(32'hC0DE_4201));
        check("ctl_op1_sflag", 160'(wci_s_SFlag), 160'(2'b01));
        check("ctl_op1_wmi_busy", 160'(wmiS0_SThreadBusy), 160'(1'b0));

        wci_cmd(3'd1, 1'b1, 8'h1C, 32'h1234_5678, 4'b0011);
        check("cfg1c_wr_sresp", 160'(wci_s_SResp), 160'(2'd1));
        check("cfg1c_sflag", 160'(wmiS0_SFlag), 160'(32'h0000_5678));

        wci_cmd(3'd2, 1'b1, 8'h0C, 32'h0, 4'hF);
        check("cfg0c_pcidev", 160'(wci_s_SData), 160'(32'h0000_BEEF));

        wmiS0_MCmd = 3'd1; wmiS0_MAddr = 14'h40; wmiS0_arg_mFlag = 32'hA5A5_0001;
        wmiS0_MDataValid = 1'b1; wmiS0_MDataByteEn = 16'hA5FF; wmiS0_MData = wd[0];
        step();
        wmiS0_MCmd = 3'd0;
        for (int k = 1; k < 4; k++) begin
            wmiS0_MData = wd[k]; wmiS0_MDataLast = (k == 3);
            step();
        end
        wmiS0_MDataValid = 1'b0; wmiS0_MDataLast = 1'b0;

        wmiS0_MCmd = 3'd2; wmiS0_MAddr = 14'h40; wmiS0_MBurstLength = 12'd4;
        step();
        wmiS0_MCmd = 3'd0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rd4_resp_%0d", k), 160'(wmiS0_SResp), 160'(2'd1));
            check($sformatf("rd4_data_%0d", k), 160'(wmiS0_SData), 160'(wd[k]));
            check($sformatf("rd4_last_%0d", k), 160'(wmiS0_SRespLast), 160'(k == 3));
            if (k == 0) check("rd4_busy", 160'(wmiS0_SThreadBusy), 160'(1'b1));
            step();
        end
        check("rd4_resp_end", 160'(wmiS0_SResp), 160'(2'd0));

        wmiS0_MCmd = 3'd2; wmiS0_MAddr = 14'h48; wmiS0_MBurstLength = 12'd0;
        step();
        wmiS0_MCmd = 3'd0;
        check("rd0_data", 160'(wmiS0_SData), 160'(wd[1]));
        check("rd0_last", 160'(wmiS0_SRespLast), 160'(1'b1));
        step();
        check("rd0_resp_end", 160'(wmiS0_SResp), 160'(2'd0));

        wci_cmd(3'd2, 1'b1, 8'h08, 32'h0, 4'hF);
        check("msgcount_1", 160'(wci_s_SData), 160'(32'd1));
        wci_cmd(3'd2, 1'b1, 8'h18, 32'h0, 4'hF);
        check("last_mflag", 160'(wci_s_SData), 160'(32'hA5A5_0001));

        wti_s_req = {3'd1, 64'h0123_4567_89AB_CDEF};
        step();
        wti_s_req = {3'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        wci_cmd(3'd2, 1'b1, 8'h10, 32'h0, 4'hF);
        check("time_lo", 160'(wci_s_SData), 160'(32'h89AB_CDEF));
        wci_cmd(3'd2, 1'b1, 8'h14, 32'h0, 4'hF);
        check("time_hi", 160'(wci_s_SData), 160'(32'h0123_4567));

        server_request_put = srv_msg(1'b1, 8'h11, 14'h100, 32'hDEAD_BEEF); EN_server_request_put = 1'b1;
        step();
        server_request_put = srv_msg(1'b1, 8'h12, 14'h104, 32'hCAFE_F00D);
        step();
        EN_server_request_put = 1'b0;
        check("srvwr_no_resp", 160'(RDY_server_response_get), 160'(1'b0));

        server_request_put = srv_msg(1'b0, 8'h11, 14'h100, 32'h0); EN_server_request_put = 1'b1;
        step();
        EN_server_request_put = 1'b0;
        check("srvrd_rdy_t1", 160'(RDY_server_response_get), 160'(1'b0));
        step();
        check("srvrd_rdy_t2", 160'(RDY_server_response_get), 160'(1'b1));
        check("srvrd_resp", 160'(server_response_get), 160'(srv_msg(1'b1, 8'h11, 14'h100, 32'hDEAD_BEEF)));
        EN_server_response_get = 1'b1;
        step();
        EN_server_response_get = 1'b0;
        check("srvrd_drained", 160'(RDY_server_response_get), 160'(1'b0));

        wmiS0_MCmd = 3'd2; wmiS0_MAddr = 14'h100; wmiS0_MBurstLength = 12'd1;
        step();
        wmiS0_MCmd = 3'd0;
        check("lane_word", 160'(wmiS0_SData), 160'(64'hCAFE_F00D_DEAD_BEEF));

        wmiS0_MCmd = 3'd1; wmiS0_MAddr = 14'h100; wmiS0_MDataValid = 1'b1; wmiS0_MDataLast = 1'b1;
        wmiS0_MData = 64'h0BAD_0BAD_1234_5678; wmiS0_MDataByteEn = 16'h00FF;
        server_request_put = srv_msg(1'b1, 8'h13, 14'h100, 32'h5555_5555); EN_server_request_put = 1'b1;
        step();
        wmiS0_MCmd = 3'd0; wmiS0_MDataValid = 1'b0; wmiS0_MDataLast = 1'b0;

        server_request_put = srv_msg(1'b0, 8'h01, 14'h100, 32'h0);
        step();
        check("pipe_rdy_put_1", 160'(RDY_server_request_put), 160'(1'b1));
        server_request_put = srv_msg(1'b0, 8'h02, 14'h100, 32'h0);
        step();
        check("pipe_rdy_put_2", 160'(RDY_server_request_put), 160'(1'b0));
        server_request_put = srv_msg(1'b0, 8'h03, 14'h104, 32'h0);
        step();
        EN_server_request_put = 1'b0;
        check("pipe_rdy_put_3", 160'(RDY_server_request_put), 160'(1'b0));
        step();
        check("collide_resp", 160'(server_response_get), 160'(srv_msg(1'b1, 8'h01, 14'h100, 32'h1234_5678)));
        EN_server_response_get = 1'b1;
        step();
        check("pipe_rdy_put_reopen", 160'(RDY_server_request_put), 160'(1'b1));
        check("pipe_second_resp", 160'(server_response_get), 160'(srv_msg(1'b1, 8'h02, 14'h100, 32'h1234_5678)));
        step();
        EN_server_response_get = 1'b0;
        check("pipe_third_dropped", 160'(RDY_server_response_get), 160'(1'b0));

        wci_cmd(3'd2, 1'b1, 8'h08, 32'h0, 4'hF);
        check("msgcount_2", 160'(wci_s_SData), 160'(32'd2));

        wmiS0_MCmd = 3'd2; wmiS0_MAddr = 14'h40; wmiS0_MBurstLength = 12'd8;
        step();
        wmiS0_MCmd = 3'd0;
        check("rst_burst_started", 160'(wmiS0_SResp), 160'(2'd1));
        RST_N = 1'b1;
        step();
        check("rst_burst_sresp", 160'(wmiS0_SResp), 160'(2'd0));
        check("rst_burst_last", 160'(wmiS0_SRespLast), 160'(1'b0));
        RST_N = 1'b0;
        step();
        check("post_rst_busy", 160'(wmiS0_SThreadBusy), 160'(1'b1));
        wci_cmd(3'd2, 1'b1, 8'h08, 32'h0, 4'hF);
        check("post_rst_msgcount", 160'(wci_s_SData), 160'(32'd0));
        check("post_rst_sflag", 160'(wci_s_SFlag), 160'(2'b00));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ocdp_dp.md
OCDP_DP -- requirements
Module: ocdp_dp

Interface
REQ-001 Parameter WMI_S0_DATAPATH_WIDTH (DW), default 32; the WMI data width, legal values 32/64/128/256, any other value SHALL stop elaboration with an error.
REQ-002 Parameter HAS_PUSH_LOGIC, default 1; when 0, server writes SHALL be dropped.
REQ-003 Parameter HAS_PULL_LOGIC, default 1; when 0, server reads SHALL return data 32'hFFFF_FFFF.
REQ-004 Parameter HAS_DEBUG_LOGIC, default 1; when 0, the message counter SHALL read as 0.
REQ-005 CLK  in  1  sole clock; all logic on rising edge.
REQ-006 RST_N  in  1  reset, synchronous and active-high (1 = reset).
REQ-007 pciDevice  in  16  device ID, readable via config space.
REQ-008 wci_s_MCmd/MAddrSpace/MByteEn/MAddr/MData  in  3/1/4/32/32  WCI request (MCmd 1=write, 2=read; MAddrSpace 1=config, 0=control).
REQ-009 wci_s_SResp/SData/SThreadBusy/SFlag  out  2/32/1/2  WCI response (SResp 1=DVA).
REQ-010 wci_s_MFlag  in  2  ignored.
REQ-011 wti_s_req  in  67  time service: [66:64] MCmd, [63:0] time.
REQ-012 wmiS0_MCmd/MReqLast/MReqInfo/MAddrSpace/MAddr/MBurstLength  in  3/1/1/1/14/12  WMI request; MAddr is a byte address; MReqInfo and MAddrSpace are ignored.
REQ-013 wmiS0_MDataValid/MDataLast/MData/MDataByteEn  in  1/1/DW/DW/4  WMI write data; only byte-enable bits [DW/8-1:0] are used.
REQ-014 wmiS0_SResp/SData/SThreadBusy/SDataThreadBusy/SRespLast/SFlag  out  2/DW/1/1/1/32  WMI response.
REQ-015 wmiS0_arg_mFlag  in  32  message metadata; wmiS0_MReset_n  in  1  ignored; wmiS0_SReset_n  out  1  equals NOT RST_N.
REQ-016 server_request_put/EN_server_request_put/RDY_server_request_put  in/in/out  153/1/1  request enqueue.
REQ-017 server_response_get/EN_server_response_get/RDY_server_response_get  out/in/out  153/1/1  response dequeue.

Function
REQ-018 Buffer SHALL be 16 KiB, organised as DW-bit words with byte write enables; it is dual-ported (port A WMI, port B server); all addresses wrap modulo 16 KiB.
REQ-019 WCI: a request accepted in cycle t SHALL give SResp=1 for exactly cycle t+1 (writes and reads alike); SResp=0 otherwise; MCmd values other than 1/2 are ignored; SThreadBusy=RST_N.
REQ-020 Config map (MAddr[7:0], writes honour MByteEn): 0x00 RO {HAS_DEBUG,HAS_PULL,HAS_PUSH, 21'b0, DW/8 in [7:0]}; 0x04 RW control (bit0 enable); 0x08 RO msgCount; 0x0C RO {16'b0,pciDevice}; 0x10/0x14 RO time lo/hi; 0x18 RO last mFlag; 0x1C RW driving wmiS0_SFlag; all other addresses read 0, writes ignored.
REQ-021 Control space: every read returns 32'hC0DE_4201; op = MAddr[4:2]: 0 clears msgCount, 1 sets enable, 2 clears enable, other ops no effect; control writes get DVA with no effect.
REQ-022 wci_s_SFlag = {1'b0, enable}.
REQ-023 When wti_s_req[66:64]==1, time register SHALL load wti_s_req[63:0] next edge.
REQ-024 WMI busy: SThreadBusy = ~enable OR read burst active; SDataThreadBusy = ~enable; requests and data presented while the corresponding busy is high are ignored.
REQ-025 WMI write: MCmd=1 latches word address MAddr>>log2(DW/8) and latches arg_mFlag into 0x18; each MDataValid beat (the first beat may coincide with the request cycle) writes enabled bytes then increments the word address; a beat with MDataLast=1 increments msgCount (32-bit, wraps).
REQ-026 WMI read: MCmd=1 is write, MCmd=2 is read; MCmd=2 in cycle t with length L (0 treated as 1) SHALL return beat k at cycle t+1+k, k=0..L-1, with SResp=1, sequential words, SRespLast=1 on beat L-1 only.
REQ-027 Server request: [152] write, [151:144] tag, [141:128] byte address ([129:128] ignored), [31:0] data, other bits ignored; it addresses the 32-bit lane (addr[log2(DW/8)-1:2]) of the addressed word.
REQ-028 Server write SHALL update that 32-bit lane and produce no response.
REQ-029 Server read put in cycle t SHALL make RDY_server_response_get high from t+2, with response {1'b1, tag, 2'b0, addr, 96'b0, data}.
REQ-030 Server response FIFO: depth 2; RDY_server_request_put = ~RST_N AND FIFO has room for all in-flight reads; put when RDY is low is ignored; get when RDY_get is low is ignored; simultaneous get and enqueue allowed.
REQ-031 Same-cycle WMI and server write to the same bytes: WMI data wins; read-during-write returns old data.

Reset
REQ-032 During reset: enable=0, msgCount=0, time=0, 0x18=0, 0x1C=0, WCI/WMI SResp=0, SRespLast=0, response FIFO empty, both RDY outputs 0, wmiS0_SReset_n=0; buffer contents are undefined; a burst in progress is abandoned.

Verification
REQ-033 Reset, then WCI config read 0x00 with DW=64 -> SResp=1 one cycle later, SData=32'hE000_0008.
REQ-034 WCI control read op1 -> SData=32'hC0DE_4201, wci_s_SFlag=2'b01, wmiS0_SThreadBusy falls to 0.
REQ-035 WMI write burst of 4 words at MAddr 0x40 with MDataLast on beat 4, then read L=4 at 0x40 -> identical data, SRespLast on 4th beat, msgCount=1.
REQ-036 Server write tag 0x11 at addr 0x100, data 0xDEADBEEF, then read at 0x100 -> RDY_get at t+2, data 0xDEADBEEF, tag 0x11.
REQ-037 Three server reads without get -> RDY_server_request_put=0 after two are in flight; one get re-asserts it.
REQ-038 Assert reset mid WMI read burst -> SResp=0 the next cycle, msgCount=0.
